// File: rtl/siso_shift_ctrl.sv
// Loopback controller for an external DEPTH-stage SISO shift register: serialises a word LSB-first,
// flushes the chain with zeros, reassembles the word from data_out and flags any corruption.
module siso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_shift_en,
    output logic             sr_data_in,
    input  logic             sr_data_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             mismatch,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_DATA = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] tx_sr_r;
    logic [WIDTH-1:0] rx_sr_r;
    logic [WIDTH-1:0] rx_next_s;
    logic [WIDTH-1:0] tx_vec_s;
    logic             accept_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept_s = 1'b1;
                    state_s  = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Received bits enter at the MSB so the first captured bit ends up in bit 0
    always_comb begin
        rx_next_s            = rx_sr_r >> 1;
        rx_next_s[WIDTH-1]   = sr_data_out;
        tx_vec_s             = tx_sr_r >> cnt_r;
    end

    // Word, capture and cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            tx_sr_r <= {WIDTH{1'b0}};
            rx_sr_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            tx_sr_r <= in_data;
            rx_sr_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r >= CNT_CAP) begin
                rx_sr_r <= rx_next_s;
            end else begin
                rx_sr_r <= rx_sr_r;
            end
        end else begin
            cnt_r   <= cnt_r;
            tx_sr_r <= tx_sr_r;
            rx_sr_r <= rx_sr_r;
        end
    end

    // Output decode from registered state; in_ready is also held low while reset is applied
    always_comb begin
        in_ready    = 1'b0;
        sr_shift_en = 1'b0;
        sr_data_in  = 1'b0;
        out_valid   = 1'b0;
        mismatch    = 1'b0;
        busy        = 1'b1;
        out_data    = rx_sr_r;
        case (state_r)
            ST_IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
            end
            ST_SHIFT: begin
                sr_shift_en = 1'b1;
                if (cnt_r < CNT_DATA) begin
                    sr_data_in = tx_vec_s[0];
                end else begin
                    sr_data_in = 1'b0;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                mismatch  = (rx_sr_r != tx_sr_r);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
